// File: rtl/i2c_bit_slave_if.sv
// Pin-level and byte-level signal bundle between the I2C bit slave and its
// bus/controller neighbours.
interface i2c_bit_slave_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       start;
  logic       stop;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_ready;

  modport slave (
    input  scl_in, sda_in, tx_data, tx_req,
    output sda_oe, start, stop, rx_valid, rx_data, tx_ready
  );

  modport master (
    output scl_in, sda_in, tx_data, tx_req,
    input  sda_oe, start, stop, rx_valid, rx_data, tx_ready
  );
endinterface

// File: rtl/i2c_bit_slave.sv
// Bit-level I2C target: START/STOP detection, byte receive with ACK, byte transmit.
// Optional glitch filter on both lines enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_bit_slave #(
  parameter logic [6:0] DEVICE_ADDR = 7'h40,
  parameter int         FILTER_LEN  = 3
) (
  input logic              clk,
  input logic              reset,
  input logic              sleep,
  i2c_bit_slave_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, RX_BITS, RX_ACK, TX_BITS, TX_ACK, WAIT_STOP
  } state_t;

  if (FILTER_LEN < 2 || FILTER_LEN > 7) begin : g_bad_filter_len
    $error("FILTER_LEN must be in 2..7");
  end

  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic scl_f, sda_f;
  logic scl_p_q, sda_p_q;

  // stage 0: pin synchronizers and edge-detect history (pure samples, no reset)
  always_ff @(posedge clk) begin
    scl_s1_q <= bus.scl_in;
    scl_s2_q <= scl_s1_q;
    sda_s1_q <= bus.sda_in;
    sda_s2_q <= sda_s1_q;
    scl_p_q  <= scl_f;
    sda_p_q  <= sda_f;
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic       scl_flt_q, sda_flt_q;
  logic [2:0] scl_cnt_q, sda_cnt_q;

  always_ff @(posedge clk) begin
    if (scl_s2_q == scl_flt_q) begin
      scl_cnt_q <= '0;
    end else if (scl_cnt_q == 3'(FILTER_LEN - 1)) begin
      scl_flt_q <= scl_s2_q;
      scl_cnt_q <= '0;
    end else begin
      scl_cnt_q <= scl_cnt_q + 3'd1;
    end
    if (sda_s2_q == sda_flt_q) begin
      sda_cnt_q <= '0;
    end else if (sda_cnt_q == 3'(FILTER_LEN - 1)) begin
      sda_flt_q <= sda_s2_q;
      sda_cnt_q <= '0;
    end else begin
      sda_cnt_q <= sda_cnt_q + 3'd1;
    end
  end

  assign scl_f = scl_flt_q;
  assign sda_f = sda_flt_q;
`else
  assign scl_f = scl_s2_q;
  assign sda_f = sda_s2_q;
`endif

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_f & ~scl_p_q;
  assign scl_fall  = ~scl_f & scl_p_q;
  // SDA edges with SCL high are bus conditions and beat any simultaneous SCL edge
  assign start_det = scl_f & sda_p_q & ~sda_f;
  assign stop_det  = scl_f & ~sda_p_q & sda_f;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic       first_q, first_d;
  logic       nack_q, nack_d;
  logic       sda_oe_q, sda_oe_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       txfull_q, txfull_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] txbuf_q, txbuf_d;
  logic [7:0] txsh_q, txsh_d;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    first_d    = first_q;
    nack_d     = nack_q;
    sda_oe_d   = sda_oe_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    txfull_d   = txfull_q;
    shift_d    = shift_q;
    txbuf_d    = txbuf_q;
    txsh_d     = txsh_q;

    if (bus.tx_req && !txfull_q) begin
      txbuf_d  = bus.tx_data;
      txfull_d = 1'b1;
    end

    if (sleep) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      bitcnt_d = '0;
    end else if (start_det) begin
      start_d  = 1'b1;
      state_d  = RX_BITS;
      bitcnt_d = '0;
      first_d  = 1'b1;
      nack_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      stop_d   = 1'b1;
      state_d  = IDLE;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        RX_BITS: begin
          if (scl_rise && bitcnt_q < 4'd8) begin
            shift_d  = {shift_q[5:0], sda_f};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              rx_data_d  = {shift_q, sda_f};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            state_d  = RX_ACK;
            bitcnt_d = '0;
            first_d  = 1'b0;
            if (first_q && rx_data_q[7:1] != DEVICE_ADDR) begin
              nack_d   = 1'b1;
              sda_oe_d = 1'b0;
            end else begin
              nack_d   = 1'b0;
              sda_oe_d = 1'b1;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            if (nack_q) begin
              state_d  = WAIT_STOP;
              sda_oe_d = 1'b0;
            end else if (txfull_q) begin
              state_d  = TX_BITS;
              txsh_d   = {txbuf_q[6:0], 1'b1};
              sda_oe_d = ~txbuf_q[7];
              txfull_d = 1'b0;
              bitcnt_d = 4'd1;
            end else begin
              state_d  = RX_BITS;
              sda_oe_d = 1'b0;
            end
          end
        end
        TX_BITS: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              state_d  = TX_ACK;
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
            end else begin
              sda_oe_d = ~txsh_q[7];
              txsh_d   = {txsh_q[6:0], 1'b1};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_f) state_d = WAIT_STOP;
          end else if (scl_fall) begin
            state_d  = TX_BITS;
            bitcnt_d = 4'd1;
            // an empty buffer at this point is an underrun: send all ones
            if (txfull_q) begin
              txsh_d   = {txbuf_q[6:0], 1'b1};
              sda_oe_d = ~txbuf_q[7];
              txfull_d = 1'b0;
            end else begin
              txsh_d   = 8'hFF;
              sda_oe_d = 1'b0;
            end
          end
        end
        IDLE, WAIT_STOP: sda_oe_d = 1'b0;
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // stage 1: control state, reset synchronously
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      first_q    <= 1'b0;
      nack_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      txfull_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      first_q    <= first_d;
      nack_q     <= nack_d;
      sda_oe_q   <= sda_oe_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      txfull_q   <= txfull_d;
    end
  end

  // stage 1: datapath shift/buffer registers, qualified by control state
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    txbuf_q <= txbuf_d;
    txsh_q  <= txsh_d;
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.start    = start_q;
  assign bus.stop     = stop_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.tx_ready = ~txfull_q;

endmodule
